syst_apb_seq: RTL

Sequencing APB master that drives the systolic-array APB slave through one complete job. It pulls `N_OPERANDS` operand words from a valid/ready stream and writes each to the load register. It then reads `N_RESULTS` words from the result register and presents them on a valid/ready output stream. It sits between the host-side command logic and `syst_APB`, replacing hand-driven bus transfers, with a per-transfer timeout for a stalled slave.

---
 rtl/syst_apb_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/syst_apb_seq.sv
// APB master sequencer for the systolic-array slave: streams N_OPERANDS operand
// writes to the load register, then N_RESULTS result reads out to a stream.
module syst_apb_seq #(
    parameter int unsigned N_OPERANDS = 7,
    parameter int unsigned N_RESULTS  = 7,
    parameter logic [31:0] WR_ADDR    = 32'd0,
    parameter logic [31:0] RD_ADDR    = 32'd4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        p_clk_i,
    input  logic        p_rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    input  logic        op_valid_i,
    input  logic [31:0] op_data_i,
    output logic        op_ready_o,
    output logic        res_valid_o,
    output logic [31:0] res_data_o,
    input  logic        res_ready_i,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic        m_sel_o,
    output logic        m_enable_o,
    output logic        m_we_o,
    input  logic        m_ready_i
);

    localparam int unsigned MAX_N = (N_OPERANDS > N_RESULTS) ? N_OPERANDS : N_RESULTS;
    localparam int unsigned CW    = $clog2(MAX_N + 1);
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS, RES_HOLD, DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] op_cnt;
    logic [CW-1:0] res_cnt;
    logic [TW-1:0] wait_cnt;
    logic [CW-1:0] op_cnt_nxt;
    logic [CW-1:0] res_cnt_nxt;
    logic [TW-1:0] wait_nxt;
    logic          timed_out;

    always_comb begin
        op_cnt_nxt  = op_cnt + CW'(1);
        res_cnt_nxt = res_cnt + CW'(1);
        wait_nxt    = wait_cnt + TW'(1);
        timed_out   = (wait_nxt == TW'(TIMEOUT));
    end

    always_ff @(posedge p_clk_i) begin
        if (p_rst_i) begin
            state       <= IDLE;
            op_cnt      <= '0;
            res_cnt     <= '0;
            wait_cnt    <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            op_ready_o  <= 1'b0;
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
            m_adr_o     <= '0;
            m_dat_o     <= '0;
            m_sel_o     <= 1'b0;
            m_enable_o  <= 1'b0;
            m_we_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state      <= FETCH;
                        op_cnt     <= '0;
                        res_cnt    <= '0;
                        err_o      <= 1'b0;
                        busy_o     <= 1'b1;
                        op_ready_o <= 1'b1;
                    end
                end
                FETCH: begin
                    if (op_valid_i) begin
                        state      <= WR_SETUP;
                        m_dat_o    <= op_data_i;
                        op_ready_o <= 1'b0;
                        m_sel_o    <= 1'b1;
                        m_enable_o <= 1'b0;
                        m_we_o     <= 1'b1;
                        m_adr_o    <= WR_ADDR;
                    end
                end
                WR_SETUP: begin
                    state      <= WR_ACCESS;
                    m_enable_o <= 1'b1;
                    wait_cnt   <= '0;
                end
                WR_ACCESS: begin
                    if (m_ready_i) begin
                        op_cnt     <= op_cnt_nxt;
                        m_enable_o <= 1'b0;
                        // After the last write, sel stays up as the first read's setup phase
                        if (op_cnt_nxt == CW'(N_OPERANDS)) begin
                            state   <= RD_SETUP;
                            m_we_o  <= 1'b0;
                            m_adr_o <= RD_ADDR;
                        end else begin
                            state      <= FETCH;
                            m_sel_o    <= 1'b0;
                            op_ready_o <= 1'b1;
                        end
                    end else if (timed_out) begin
                        state      <= IDLE;
                        err_o      <= 1'b1;
                        busy_o     <= 1'b0;
                        m_sel_o    <= 1'b0;
                        m_enable_o <= 1'b0;
                        m_we_o     <= 1'b0;
                    end else begin
                        wait_cnt <= wait_nxt;
                    end
                end
                RD_SETUP: begin
                    state      <= RD_ACCESS;
                    m_enable_o <= 1'b1;
                    wait_cnt   <= '0;
                end
                RD_ACCESS: begin
                    if (m_ready_i) begin
                        state       <= RES_HOLD;
                        res_data_o  <= m_dat_i;
                        res_valid_o <= 1'b1;
                        m_sel_o     <= 1'b0;
                        m_enable_o  <= 1'b0;
                    end else if (timed_out) begin
                        state      <= IDLE;
                        err_o      <= 1'b1;
                        busy_o     <= 1'b0;
                        m_sel_o    <= 1'b0;
                        m_enable_o <= 1'b0;
                    end else begin
                        wait_cnt <= wait_nxt;
                    end
                end
                RES_HOLD: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        res_cnt     <= res_cnt_nxt;
                        if (res_cnt_nxt == CW'(N_RESULTS)) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state   <= RD_SETUP;
                            m_sel_o <= 1'b1;
                            m_we_o  <= 1'b0;
                            m_adr_o <= RD_ADDR;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
